// File: rtl/iq_rx_pkg.sv
// iq_rx_pkg: shared types and width constants for the IQ receive scheduler
package iq_rx_pkg;
  localparam int SAMPLE_W = 32;
  localparam int DEPTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  typedef struct packed {
    logic [SAMPLE_W-1:0] rx1_i;
    logic [SAMPLE_W-1:0] rx1_q;
    logic [SAMPLE_W-1:0] rx2_i;
    logic [SAMPLE_W-1:0] rx2_q;
  } frame_t;
endpackage

// File: rtl/iq_frame_fifo.sv
// iq_frame_fifo: single-clock frame FIFO with registered read data and synchronous clear
// Ports: clk/rst_n clock and async active-low reset; clr empties the FIFO;
// wr_en/wr_data push; rd_en pops into rd_data; count/full/empty report occupancy.
// Callers never push when full without popping, nor pop when empty.
module iq_frame_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic [W-1:0] rd_data_q;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  // Pointers are AW bits wide, so power-of-two DEPTH wraps them naturally.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign empty   = count_q == '0;
endmodule

// File: rtl/iq_rx_scheduler.sv
// iq_rx_scheduler: assembles RX1/RX2 DDC samples into frames and streams them to the MCU bus
// Ports: clk_in/reset_n clock and async active-low reset; rx2_en selects dual-receiver frames;
// rx1_*/rx2_* DDC strobes and samples; rd_req streaming level, rd_clk pop pulse;
// out_* head frame with out_valid; overrun/underrun sticky flags cleared by err_clr;
// fill_level frames stored.
module iq_rx_scheduler
  import iq_rx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SW = SAMPLE_W
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic                   rx2_en,
  input  logic                   rx1_valid,
  input  logic [SW-1:0]          rx1_i,
  input  logic [SW-1:0]          rx1_q,
  input  logic                   rx2_valid,
  input  logic [SW-1:0]          rx2_i,
  input  logic [SW-1:0]          rx2_q,
  input  logic                   rd_req,
  input  logic                   rd_clk,
  input  logic                   err_clr,
  output logic [SW-1:0]          out_rx1_i,
  output logic [SW-1:0]          out_rx1_q,
  output logic [SW-1:0]          out_rx2_i,
  output logic [SW-1:0]          out_rx2_q,
  output logic                   out_valid,
  output logic                   overrun,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fill_level
);
  state_t state_q;
  logic rx2_en_q, h1_q, h2_q, out_valid_q, overrun_q, underrun_q;
  logic [2*SW-1:0] s1_q, s2_q;
  logic stream, en_chg, push, pop, wr, full, empty;
  logic [4*SW-1:0] wr_frame, rd_frame;
  // A mode change invalidates half-built frames, so it blocks the push that cycle.
  always_comb begin
    stream   = state_q == STREAM;
    en_chg   = rx2_en != rx2_en_q;
    push     = stream && !en_chg && h1_q && (h2_q || !rx2_en);
    pop      = stream && rd_clk && !empty;
    wr       = push && (!full || pop);
    wr_frame = {s1_q, s2_q & {2*SW{rx2_en}}};
  end
  iq_frame_fifo #(.DEPTH(DEPTH), .W(4*SW)) u_fifo (
    .clk     (clk_in),
    .rst_n   (reset_n),
    .clr     (!stream),
    .wr_en   (wr),
    .wr_data (wr_frame),
    .rd_en   (pop),
    .rd_data (rd_frame),
    .count   (fill_level),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      rx2_en_q    <= 1'b0;
      h1_q        <= 1'b0;
      h2_q        <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q  <= state_q == IDLE ? (rd_req ? STREAM : IDLE) :
                  state_q == STREAM ? (rd_req ? STREAM : FLUSH) : IDLE;
      rx2_en_q <= rx2_en;
      if (rx1_valid) s1_q <= {rx1_i, rx1_q};
      if (rx2_valid) s2_q <= {rx2_i, rx2_q};
      // A fresh strobe in the push cycle starts the next frame.
      h1_q <= stream && !en_chg && (rx1_valid || (h1_q && !push));
      h2_q <= stream && !en_chg && (rx2_valid || (h2_q && !push));
      if (stream && rd_clk) out_valid_q <= !empty;
      overrun_q  <= !err_clr && (overrun_q || (push && full && !pop));
      underrun_q <= !err_clr && (underrun_q || (stream && rd_clk && empty));
    end
  assign {out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q} = rd_frame;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;
endmodule

// File: tb/tb_iq_rx_scheduler.sv
// tb_iq_rx_scheduler: scoreboard bench with a queue-based reference model
module tb_iq_rx_scheduler;
  import iq_rx_pkg::*;
  localparam int DEPTH = 8;
  localparam int SW = 32;
  logic clk_in = 0, reset_n = 0, rx2_en = 0, rx1_valid = 0, rx2_valid = 0;
  logic rd_req = 0, rd_clk = 0, err_clr = 0;
  logic [SW-1:0] rx1_i = 0, rx1_q = 0, rx2_i = 0, rx2_q = 0;
  logic [SW-1:0] out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q;
  logic out_valid, overrun, underrun;
  logic [3:0] fill_level;
  always #5 clk_in = ~clk_in;
  iq_rx_scheduler #(.DEPTH(DEPTH), .SW(SW)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .rx2_en(rx2_en),
    .rx1_valid(rx1_valid), .rx1_i(rx1_i), .rx1_q(rx1_q),
    .rx2_valid(rx2_valid), .rx2_i(rx2_i), .rx2_q(rx2_q),
    .rd_req(rd_req), .rd_clk(rd_clk), .err_clr(err_clr),
    .out_rx1_i(out_rx1_i), .out_rx1_q(out_rx1_q), .out_rx2_i(out_rx2_i), .out_rx2_q(out_rx2_q),
    .out_valid(out_valid), .overrun(overrun), .underrun(underrun), .fill_level(fill_level)
  );
  int tests = 0, fails = 0;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct packed {logic v; frame_t f;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  frame_t fifo_q[$];
  frame_t held, last_out;
  int mstate, m_fill;
  bit mmode, mh1, mh2, mov, mun, mval;
  function void model_reset();
    mstate = 0; mmode = 0; mh1 = 0; mh2 = 0; mov = 0; mun = 0; mval = 0;
    held = '0; last_out = '0; m_fill = 0;
    fifo_q.delete();
    exp_q.delete();
  endfunction
  // One clock of behaviour: pop first, then store the completed frame, then capture.
  function void model_step();
    bit stream, chg, ready, un_set, ov_set;
    frame_t f;
    stream = mstate == 1;
    chg = rx2_en != mmode;
    ready = stream && !chg && mh1 && (mh2 || !rx2_en);
    f = held;
    if (!rx2_en) begin f.rx2_i = 0; f.rx2_q = 0; end
    un_set = 0; ov_set = 0;
    if (stream && rd_clk) begin
      if (fifo_q.size() > 0) begin last_out = fifo_q.pop_front(); mval = 1; end
      else begin mval = 0; un_set = 1; end
    end
    if (rd_clk) exp_q.push_back({mval, last_out});
    if (ready) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(f);
      else ov_set = 1;
    end
    mov = !err_clr && (mov || ov_set);
    mun = !err_clr && (mun || un_set);
    if (!stream || chg) begin mh1 = 0; mh2 = 0; end
    else begin
      if (ready) begin mh1 = 0; mh2 = 0; end
      if (rx1_valid) mh1 = 1;
      if (rx2_valid) mh2 = 1;
    end
    if (rx1_valid) begin held.rx1_i = rx1_i; held.rx1_q = rx1_q; end
    if (rx2_valid) begin held.rx2_i = rx2_i; held.rx2_q = rx2_q; end
    if (!stream) fifo_q.delete();
    mstate = mstate == 0 ? (rd_req ? 1 : 0) : mstate == 1 ? (rd_req ? 1 : 2) : 0;
    mmode = rx2_en;
    m_fill = fifo_q.size();
  endfunction
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      if (reset_n) model_step(); else model_reset();
      #1;
    end
  endtask
  task automatic frame1(logic [31:0] i, logic [31:0] q);
    rx1_i = i; rx1_q = q; rx1_valid = 1;
    tick();
    rx1_valid = 0;
    tick();
  endtask
  task automatic rd1();
    rd_clk = 1;
    tick();
    rd_clk = 0;
  endtask
  logic rd_seen = 0;
  always @(posedge clk_in) rd_seen <= rd_clk;
  always @(negedge clk_in)
    if (reset_n) begin
      chk("fill_level", fill_level, m_fill);
      chk("overrun", overrun, mov);
      chk("underrun", underrun, mun);
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard: DUT output with no expected entry");
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_valid", out_valid, mon_e.v);
          chk("out_frame", {out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q}, mon_e.f);
        end
      end
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    tick(2);
    chk("rst_frame", {out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q}, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", {overrun, underrun}, 0);
    chk("rst_fill", fill_level, 0);
    reset_n = 1;
    tick(2);
    rd_req = 1;
    tick(2);
    frame1(32'h11111111, 32'h22222222);
    tick(2);
    rd1();
    chk("r032_rx1_i", out_rx1_i, 32'h11111111);
    chk("r032_rx1_q", out_rx1_q, 32'h22222222);
    chk("r032_rx2", {out_rx2_i, out_rx2_q}, 0);
    chk("r032_valid", out_valid, 1);
    tick(2);
    rx2_en = 1;
    tick(2);
    rx1_i = $urandom; rx1_q = $urandom; rx1_valid = 1;
    tick();
    rx1_valid = 0;
    tick(2);
    rx2_i = $urandom; rx2_q = $urandom; rx2_valid = 1;
    tick();
    rx2_valid = 0;
    tick(4);
    chk("r033_fill", fill_level, 1);
    rd1();
    tick(2);
    rx2_en = 0;
    tick(2);
    for (int k = 1; k <= 9; k++) frame1(k, k + 32'h100);
    tick(2);
    chk("r034_fill", fill_level, 8);
    chk("r034_overrun", overrun, 1);
    repeat (8) begin rd1(); tick(); end
    chk("r034_drained", fill_level, 0);
    chk("r034_last", out_rx1_i, 8);
    rd1();
    chk("r035_valid", out_valid, 0);
    chk("r035_hold", out_rx1_i, 8);
    chk("r035_underrun", underrun, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("r035_clr", {overrun, underrun}, 0);
    for (int s = 0; s < 6; s++) begin
      int pr;
      pr = (s % 2) ? 10 : 60;
      repeat (500) begin
        rx1_i = $urandom; rx1_q = $urandom; rx2_i = $urandom; rx2_q = $urandom;
        rx1_valid = $urandom_range(0, 99) < 40;
        rx2_valid = $urandom_range(0, 99) < 40;
        rd_clk = $urandom_range(0, 99) < pr;
        rd_req = $urandom_range(0, 299) != 0;
        err_clr = $urandom_range(0, 49) == 0;
        if ($urandom_range(0, 199) == 0) rx2_en = ~rx2_en;
        tick();
      end
    end
    {rx1_valid, rx2_valid, rd_clk, err_clr} = 0;
    rd_req = 1;
    tick(4);
    repeat (DEPTH + 1) begin rd1(); tick(); end
    tick(2);
    for (int k = 0; k < 5; k++) frame1($urandom, $urandom);
    tick(2);
    chk("r036_fill5", fill_level, 5);
    rd_req = 0;
    tick();
    chk("r036_flush", fill_level, 5);
    tick();
    chk("r036_idle", fill_level, 0);
    repeat (3) frame1($urandom, $urandom);
    chk("r036_idle_strobe", fill_level, 0);
    rd_req = 1;
    tick(2);
    for (int k = 0; k < 5; k++) frame1(32'hA0 + k, 32'hB0 + k);
    tick(2);
    rd1();
    tick();
    chk("r037_fill4", fill_level, 4);
    @(negedge clk_in);
    #2 reset_n = 0;
    #1;
    chk("r037_fill", fill_level, 0);
    chk("r037_frame", {out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q}, 0);
    chk("r037_valid", out_valid, 0);
    rd_req = 0;
    tick(2);
    reset_n = 1;
    repeat (3) frame1($urandom, $urandom);
    chk("r029_idle_wait", fill_level, 0);
    rd_req = 1;
    tick(2);
    frame1(32'h5, 32'h6);
    tick(2);
    chk("r029_resume", fill_level, 1);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
